// File: rtl/enemy_ctrl_pkg.sv
// Shared types and defaults for the enemy sprite sequencing controller.
package enemy_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_GEN   = 3'd2,
    S_COLL  = 3'd3,
    S_APPLY = 3'd4,
    S_DRAW  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int MOVE_DIV_DEF     = 4;
  localparam int COLL_LAT_DEF     = 2;
  localparam int DRAW_TIMEOUT_DEF = 1023;
  localparam int DRAW_TW          = 10;
  localparam int SPRITE_PIXELS    = 256;

endpackage

// File: rtl/draw_watchdog.sv
// Cycle timer with clear/enable and terminal-count flag; guards a draw handshake.
module draw_watchdog #(
  parameter int W     = 10,
  parameter int LIMIT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [W-1:0] timer;

  always_ff @(posedge clock) begin
    if (!reset)   timer <= '0;
    else if (clr) timer <= '0;
    else if (en)  timer <= timer + W'(1);
  end

  assign tc = (timer == W'(LIMIT));

endmodule

// File: rtl/enemy_control.sv
// Per-frame sequencer for the enemy sprite engine: move generation, collision
// settle, move apply and a watchdog-guarded draw handshake.
module enemy_control
  import enemy_ctrl_pkg::*;
#(
  parameter int MOVE_DIV     = MOVE_DIV_DEF,
  parameter int COLL_LAT     = COLL_LAT_DEF,
  parameter int DRAW_TIMEOUT = DRAW_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic       draw_done,
  output logic       init,
  output logic       idle,
  output logic       gen_move,
  output logic       apply_move,
  output logic       draw,
  output logic       busy,
  output logic [7:0] frame_count,
  output logic       draw_timeout_err,
  output logic       tick_overrun
);

  state_t     state, state_nxt;
  logic       out_en;
  logic       go, move_frame, wd_tc;
  logic [7:0] move_cnt;
  logic [3:0] coll_cnt;
  logic       tick_pend;

  assign go         = (frame_tick | tick_pend) & ~pause;
  assign move_frame = (move_cnt == 8'(MOVE_DIV - 1));

  draw_watchdog #(.W(DRAW_TW), .LIMIT(DRAW_TIMEOUT)) u_wd (
    .clock (clock),
    .reset (reset),
    .clr   (state != S_DRAW),
    .en    (state == S_DRAW),
    .tc    (wd_tc)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  // out_en holds S_INIT for one extra cycle so the init strobe is visible
  // the cycle after reset release while all outputs stay low during reset.
  always_comb begin
    state_nxt  = state;
    init       = 1'b0;
    idle       = 1'b0;
    gen_move   = 1'b0;
    apply_move = 1'b0;
    draw       = 1'b0;
    case (state)
      S_INIT: begin
        init = 1'b1;
        if (out_en) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        idle = 1'b1;
        if (go) state_nxt = move_frame ? S_GEN : S_DRAW;
      end
      S_GEN: begin
        gen_move  = 1'b1;
        state_nxt = S_COLL;
      end
      S_COLL: begin
        if (coll_cnt == 4'(COLL_LAT - 1)) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        apply_move = 1'b1;
        state_nxt  = S_DRAW;
      end
      S_DRAW: begin
        draw = 1'b1;
        if (draw_done || wd_tc) state_nxt = S_DONE;
      end
      S_DONE: begin
        idle = 1'b1;
        if (!draw_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
    if (!out_en) begin
      init       = 1'b0;
      idle       = 1'b0;
      gen_move   = 1'b0;
      apply_move = 1'b0;
      draw       = 1'b0;
    end
  end

  assign busy = out_en & (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_en           <= 1'b0;
      move_cnt         <= 8'd0;
      coll_cnt         <= 4'd0;
      tick_pend        <= 1'b0;
      frame_count      <= 8'd0;
      draw_timeout_err <= 1'b0;
      tick_overrun     <= 1'b0;
    end else begin
      out_en   <= 1'b1;
      coll_cnt <= (state == S_COLL) ? coll_cnt + 4'd1 : 4'd0;
      if (state == S_IDLE) begin
        if (pause) begin
          tick_pend <= 1'b0;
        end else if (go) begin
          tick_pend   <= 1'b0;
          frame_count <= frame_count + 8'd1;
          move_cnt    <= move_frame ? 8'd0 : move_cnt + 8'd1;
        end
      end else if (frame_tick) begin
        if (tick_pend) tick_overrun <= 1'b1;
        else           tick_pend    <= 1'b1;
      end
      // A draw_done landing on the terminal cycle counts as a clean finish.
      if (state == S_DRAW && wd_tc && !draw_done) draw_timeout_err <= 1'b1;
    end
  end

endmodule
